rv_uart_fifo_io: RTL and testbench
==================================

// Module: rv_uart_fifo_io
// PURPOSE
//  Memory-mapped multi-channel UART TX peripheral for the RISC-V SoC I/O bus.
//  Provides NUM_CH independent 8N1 transmitters, each fed by its own byte FIFO.
//  Each channel has a runtime-programmable baud divisor, plus status and control registers.
//  Sits beside svc_rv_soc_bram on the io_* bus; replaces the single fixed-rate UART for multi-console demos.
// PARAMETERS
//  NUM_CH      2            number of TX channels (1..8)
//  FIFO_DEPTH  16           bytes per channel FIFO; power of two, >=2
//  CLOCK_FREQ  25_000_000   clk frequency in Hz
//  BAUD_RATE   115_200      reset baud rate; DIV reset = CLOCK_FREQ/BAUD_RATE-1
//  DIV_W       16           width of baud divisor register
// PORTS
//  clk       in   1         system clock
//  rst       in   1         asynchronous reset, active-high
//  io_wen    in   1         write strobe, one cycle per write
//  io_waddr  in   32        write byte address; bits [7:0] decoded
//  io_wdata  in   32        write data
//  io_wstrb  in   4         byte enables
//  io_ren    in   1         read strobe
//  io_raddr  in   32        read byte address; bits [7:0] decoded
//  io_rdata  out  32        read data, registered
//  uart_tx   out  NUM_CH    serial outputs; idle high
//  tx_irq    out  NUM_CH    per-channel level: FIFO empty AND transmitter idle AND IE set
// BEHAVIOUR
//  Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
//  Reset values:
//   - uart_tx all 1; io_rdata 0; tx_irq 0
//   - FIFOs empty; DIV = CLOCK_FREQ/BAUD_RATE-1; CTRL = 0x1 (EN=1, IE=0); OVF = 0
//   - reset mid-frame aborts the frame; the line goes high immediately
//  Address map: channel n is at byte offset n*16; other addresses in 0x00-0xFF are unmapped.
//   - +0x0 TXDATA: W; pushes wdata[7:0] when wstrb[0]=1; reads return 0
//   - +0x4 STATUS: R = {count[23:16], 12'b0, OVF[3], BUSY[2], FULL[1], EMPTY[0]}
//     W with wdata[3]=1 and wstrb[0]=1 clears OVF
//   - +0x8 DIV: RW, DIV_W bits, zero-extended on read; honours wstrb per byte
//   - +0xC CTRL: RW; bit0 EN, bit1 IE, bit2 FLUSH (self-clearing, reads 0)
//  Bus timing:
//   - reads: io_rdata is valid the cycle after io_ren and holds until the next io_ren
//   - unmapped reads return 0; unmapped writes are ignored
//   - io_ren and io_wen in the same cycle are both serviced; STATUS read reflects pre-write state
//  FIFO behaviour:
//   - FIFO full test uses current-cycle state; a push to a full FIFO is dropped and sets sticky OVF, even if a pop happens that cycle
//   - count spans 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH
//   - FLUSH empties the FIFO in one cycle; a frame already in progress completes
//   - a push in the same cycle as FLUSH is discarded
//  Transmitter FSM per channel: IDLE -> START -> DATA -> STOP -> IDLE
//   - IDLE: pops the FIFO head and moves to START when EN=1 and FIFO not empty
//   - START drives 0; DATA drives 8 bits LSB first; STOP drives 1
//   - each bit lasts DIV+1 clocks, so a frame is 10*(DIV+1) clocks
//   - uart_tx falls one cycle after the pop
//   - back-to-back frames: STOP -> START with no idle bit if the FIFO is non-empty
//  Mid-operation changes:
//   - DIV is sampled at START entry; a DIV write mid-frame applies from the next frame
//   - EN=0 mid-frame: the current frame finishes, then the channel holds in IDLE
//   - BUSY = state != IDLE
//  DIV=0 is legal: each bit lasts 1 clock.
// TESTING (NUM_CH=2, FIFO_DEPTH=4, CLOCK_FREQ=1_000_000, BAUD_RATE=100_000 -> DIV=9)
//  1. Write 0x48 to ch0 TXDATA -> uart_tx[0] low 1 cycle later; bits 0,0,0,1,0,0,1,0 each 10 clk; stop bit; frame=100 clk; uart_tx[1] stays 1.
//  2. Write 6 bytes to ch1 in back-to-back cycles -> 1st is popped immediately, then 4 queued, 6th dropped; OVF=1, FULL=1; 5 frames sent with no gaps.
//  3. Write 0x8 to ch1 STATUS -> OVF=0. Write DIV=0 on ch0 mid-frame -> current frame stays 100 clk, next frame 10 clk.
//  4. Queue 3 bytes, EN=0 during the 1st frame -> 1st frame completes, uart_tx stays 1, count=2; EN=1 resumes; FLUSH mid-frame -> count=0, frame completes.
//  5. Set IE=1; after the last STOP -> tx_irq[0]=1; a push deasserts it. Read 0x40 (unmapped) -> io_rdata=0 next cycle.
//  6. Assert rst mid-DATA -> uart_tx=1 and FIFO empty without waiting for a clk edge; DIV=9 after release.

Source files
------------

// File: rtl/rv_uart_fifo_io.sv
// ============================================================================
//  Module   : rv_uart_fifo_io
//  Purpose  : Memory-mapped multi-channel 8N1 UART transmitter. Each channel
//             has its own byte FIFO, runtime baud divisor, STATUS and CTRL.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_uart_fifo_io #(
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int CLOCK_FREQ = 25_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DIV_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              io_wen,
    input  logic [31:0]       io_waddr,
    input  logic [31:0]       io_wdata,
    input  logic [3:0]        io_wstrb,
    input  logic              io_ren,
    input  logic [31:0]       io_raddr,
    output logic [31:0]       io_rdata,
    output logic [NUM_CH-1:0] uart_tx,
    output logic [NUM_CH-1:0] tx_irq
);

    localparam int              AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              CW      = AW + 1;
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(CLOCK_FREQ / BAUD_RATE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Per-byte write mask for the DIV register, expanded from the strobes.
    logic [31:0]            w_bmask;
    logic [NUM_CH:0][31:0]  w_rchain;
    logic [31:0]            rdata_q;
    logic                   w_unused;

    assign w_bmask     = {{8{io_wstrb[3]}}, {8{io_wstrb[2]}}, {8{io_wstrb[1]}}, {8{io_wstrb[0]}}};
    assign w_rchain[0] = '0;
    assign w_unused    = ^{io_waddr[31:8], io_raddr[31:8], io_wdata, io_wstrb, w_bmask};

    generate
        for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
            logic [7:0]       mem_q [FIFO_DEPTH];
            logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
            logic [CW-1:0]    cnt_q, cnt_d;
            logic [DIV_W-1:0] div_q, div_d, bdiv_q, bdiv_d, bcnt_q, bcnt_d;
            logic             en_q, en_d, ie_q, ie_d, ovf_q, ovf_d;
            state_t           st_q, st_d;
            logic [2:0]       bit_q, bit_d;
            logic [7:0]       sh_q, sh_d;
            logic             tx_q, tx_d;
            logic             w_sel, w_push_req, w_flush, w_full, w_empty;
            logic             w_push, w_pop, w_bend, w_rsel;
            logic [31:0]      w_status, w_rval;

            assign w_sel      = io_wen && (io_waddr[7:4] == 4'(n)) && (io_waddr[1:0] == 2'b00);
            assign w_push_req = w_sel && (io_waddr[3:2] == 2'd0) && io_wstrb[0];
            assign w_flush    = w_sel && (io_waddr[3:2] == 2'd3) && io_wstrb[0] && io_wdata[2];
            assign w_full     = (cnt_q == CW'(FIFO_DEPTH));
            assign w_empty    = (cnt_q == '0);
            // Full test uses this cycle's count: a concurrent pop never makes room.
            assign w_push     = w_push_req && !w_full && !w_flush;
            assign w_bend     = (bcnt_q == bdiv_q);
            // Pop from IDLE, or straight out of the last STOP cycle for gap-free frames.
            assign w_pop      = en_q && !w_empty && !w_flush &&
                                ((st_q == S_IDLE) || ((st_q == S_STOP) && w_bend));

            // FIFO pointer and occupancy update; FLUSH discards everything queued.
            always_comb begin
                wptr_d = wptr_q;
                rptr_d = rptr_q;
                cnt_d  = cnt_q;
                if (w_flush) begin
                    rptr_d = wptr_q;
                    cnt_d  = '0;
                end else begin
                    if (w_push) wptr_d = wptr_q + 1'b1;
                    if (w_pop)  rptr_d = rptr_q + 1'b1;
                    cnt_d = cnt_q + CW'(w_push) - CW'(w_pop);
                end
            end

            // Register-file writes: DIV per byte, CTRL bits, sticky overflow flag.
            always_comb begin
                div_d = div_q;
                en_d  = en_q;
                ie_d  = ie_q;
                ovf_d = ovf_q;
                if (w_sel && (io_waddr[3:2] == 2'd1) && io_wstrb[0] && io_wdata[3]) ovf_d = 1'b0;
                if (w_push_req && w_full) ovf_d = 1'b1;
                if (w_sel && (io_waddr[3:2] == 2'd2))
                    div_d = (div_q & ~w_bmask[DIV_W-1:0]) | (io_wdata[DIV_W-1:0] & w_bmask[DIV_W-1:0]);
                if (w_sel && (io_waddr[3:2] == 2'd3) && io_wstrb[0]) begin
                    en_d = io_wdata[0];
                    ie_d = io_wdata[1];
                end
            end

            // Transmit FSM; the divisor is latched at START so mid-frame DIV writes wait.
            always_comb begin
                st_d   = st_q;
                bcnt_d = bcnt_q;
                bdiv_d = bdiv_q;
                bit_d  = bit_q;
                sh_d   = sh_q;
                tx_d   = tx_q;
                if (w_pop) begin
                    st_d   = S_START;
                    bcnt_d = '0;
                    bdiv_d = div_q;
                    sh_d   = mem_q[rptr_q];
                    tx_d   = 1'b0;
                end else begin
                    case (st_q)
                        S_IDLE: tx_d = 1'b1;
                        S_START: begin
                            if (w_bend) begin
                                st_d   = S_DATA;
                                bcnt_d = '0;
                                bit_d  = 3'd0;
                                tx_d   = sh_q[0];
                            end else begin
                                bcnt_d = bcnt_q + 1'b1;
                            end
                        end
                        S_DATA: begin
                            if (w_bend) begin
                                bcnt_d = '0;
                                if (bit_q == 3'd7) begin
                                    st_d = S_STOP;
                                    tx_d = 1'b1;
                                end else begin
                                    bit_d = bit_q + 1'b1;
                                    sh_d  = {1'b0, sh_q[7:1]};
                                    tx_d  = sh_q[1];
                                end
                            end else begin
                                bcnt_d = bcnt_q + 1'b1;
                            end
                        end
                        S_STOP: begin
                            if (w_bend) begin
                                st_d = S_IDLE;
                                tx_d = 1'b1;
                            end else begin
                                bcnt_d = bcnt_q + 1'b1;
                            end
                        end
                        default: st_d = S_IDLE;
                    endcase
                end
            end

            // FIFO storage; contents need no reset since the pointers define validity.
            always_ff @(posedge clk) begin
                if (w_push) mem_q[wptr_q] <= io_wdata[7:0];
            end

            // Channel state registers; reset aborts any frame and idles the line.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wptr_q <= '0;
                    rptr_q <= '0;
                    cnt_q  <= '0;
                    div_q  <= DIV_RST;
                    en_q   <= 1'b1;
                    ie_q   <= 1'b0;
                    ovf_q  <= 1'b0;
                    st_q   <= S_IDLE;
                    bcnt_q <= '0;
                    bdiv_q <= '0;
                    bit_q  <= 3'd0;
                    sh_q   <= 8'd0;
                    tx_q   <= 1'b1;
                end else begin
                    wptr_q <= wptr_d;
                    rptr_q <= rptr_d;
                    cnt_q  <= cnt_d;
                    div_q  <= div_d;
                    en_q   <= en_d;
                    ie_q   <= ie_d;
                    ovf_q  <= ovf_d;
                    st_q   <= st_d;
                    bcnt_q <= bcnt_d;
                    bdiv_q <= bdiv_d;
                    bit_q  <= bit_d;
                    sh_q   <= sh_d;
                    tx_q   <= tx_d;
                end
            end

            assign w_status = {8'h00, 8'(cnt_q), 12'h000, ovf_q, (st_q != S_IDLE), w_full, w_empty};
            assign w_rsel   = (io_raddr[7:4] == 4'(n)) && (io_raddr[1:0] == 2'b00);
            assign w_rval   = !w_rsel                   ? 32'd0 :
                              (io_raddr[3:2] == 2'd1)   ? w_status :
                              (io_raddr[3:2] == 2'd2)   ? 32'(div_q) :
                              (io_raddr[3:2] == 2'd3)   ? {30'd0, ie_q, en_q} : 32'd0;
            assign w_rchain[n+1] = w_rchain[n] | w_rval;

            assign uart_tx[n] = tx_q;
            assign tx_irq[n]  = w_empty && (st_q == S_IDLE) && ie_q;
        end
    endgenerate

    // Registered read port; data holds until the next read strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         rdata_q <= '0;
        else if (io_ren) rdata_q <= w_rchain[NUM_CH];
    end

    assign io_rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_rv_uart_fifo_io.sv
// ============================================================================
//  Module   : tb_rv_uart_fifo_io
//  Purpose  : Directed self-checking bench for rv_uart_fifo_io
//             (NUM_CH=2, FIFO_DEPTH=4, 1 MHz clock, 100 kbaud -> DIV=9).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_uart_fifo_io;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        io_wen = 1'b0;
    logic [31:0] io_waddr = '0;
    logic [31:0] io_wdata = '0;
    logic [3:0]  io_wstrb = '0;
    logic        io_ren = 1'b0;
    logic [31:0] io_raddr = '0;
    logic [31:0] io_rdata;
    logic [1:0]  uart_tx;
    logic [1:0]  tx_irq;

    int checks = 0;
    int errors = 0;

    rv_uart_fifo_io #(
        .NUM_CH    (2),
        .FIFO_DEPTH(4),
        .CLOCK_FREQ(1_000_000),
        .BAUD_RATE (100_000),
        .DIV_W     (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .io_wen  (io_wen),
        .io_waddr(io_waddr),
        .io_wdata(io_wdata),
        .io_wstrb(io_wstrb),
        .io_ren  (io_ren),
        .io_raddr(io_raddr),
        .io_rdata(io_rdata),
        .uart_tx (uart_tx),
        .tx_irq  (tx_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before end of test sequence");
        $fatal(1, "watchdog");
    end

    // One bus write, sampled at the next rising edge; returns 1 time unit after it.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        io_wen = 1'b1; io_waddr = a; io_wdata = d; io_wstrb = s;
        @(posedge clk); #1;
        io_wen = 1'b0; io_wstrb = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        io_ren = 1'b1; io_raddr = a;
        @(posedge clk); #1;
        io_ren = 1'b0;
        d = io_rdata;
    endtask

    // Records the first sample of each of 10 bit periods, starting in the first START cycle.
    task automatic capture_frame(input int ch, input int div, output logic [9:0] bits, output logic stable);
        logic v0;
        stable = 1'b1;
        for (int b = 0; b < 10; b++) begin
            v0 = uart_tx[ch];
            for (int c = 0; c <= div; c++) begin
                if (uart_tx[ch] !== v0) stable = 1'b0;
                @(posedge clk); #1;
            end
            bits[b] = v0;
        end
    endtask

    task automatic test_reset;
        logic [31:0] r;
        checks++; if (uart_tx !== 2'b11) begin errors++; $display("FAIL reset_tx: got %b want 11", uart_tx); end
        checks++; if (io_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", io_rdata); end
        checks++; if (tx_irq !== 2'b00) begin errors++; $display("FAIL reset_irq: got %b want 00", tx_irq); end
        bus_read(32'h04, r);
        checks++; if (r !== 32'h0000_0001) begin errors++; $display("FAIL reset_status: got %h want 00000001", r); end
        bus_read(32'h18, r);
        checks++; if (r !== 32'd9) begin errors++; $display("FAIL reset_div: got %h want 00000009", r); end
        bus_read(32'h0C, r);
        checks++; if (r !== 32'd1) begin errors++; $display("FAIL reset_ctrl: got %h want 00000001", r); end
        bus_read(32'h00, r);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL txdata_read: got %h want 0", r); end
    endtask

    task automatic test_single_frame;
        logic [9:0]  bits;
        logic        st;
        logic [31:0] r;
        bus_write(32'h00, 32'h48, 4'h1);
        checks++; if (uart_tx !== 2'b11) begin errors++; $display("FAIL tx_before_pop: got %b want 11", uart_tx); end
        @(posedge clk); #1;
        checks++; if (uart_tx[0] !== 1'b0) begin errors++; $display("FAIL tx_fall: got %b want 0", uart_tx[0]); end
        capture_frame(0, 9, bits, st);
        checks++; if (bits !== 10'b1_0100_1000_0 || !st) begin errors++; $display("FAIL frame_48: got %b stable=%b want 1010010000", bits, st); end
        checks++; if (uart_tx !== 2'b11) begin errors++; $display("FAIL idle_after_48: got %b want 11", uart_tx); end
        bus_read(32'h04, r);
        checks++; if (r !== 32'h0000_0001) begin errors++; $display("FAIL status_after_48: got %h want 00000001", r); end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  data [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        logic [9:0]  bits;
        logic        st;
        logic [31:0] r;
        for (int i = 0; i < 6; i++) bus_write(32'h10, {24'd0, data[i]}, 4'h1);
        bus_read(32'h14, r);
        checks++; if (r !== 32'h0004_000E) begin errors++; $display("FAIL status_full_ovf: got %h want 0004000E", r); end
        // first frame began at the edge after the first write; skip to its end
        repeat (95) @(posedge clk);
        #1;
        for (int f = 1; f < 5; f++) begin
            capture_frame(1, 9, bits, st);
            checks++;
            if (bits !== {1'b1, data[f], 1'b0} || !st) begin
                errors++; $display("FAIL b2b_frame%0d: got %b stable=%b want %b", f, bits, st, {1'b1, data[f], 1'b0});
            end
        end
        checks++; if (uart_tx !== 2'b11) begin errors++; $display("FAIL b2b_idle: got %b want 11", uart_tx); end
        bus_read(32'h14, r);
        checks++; if (r !== 32'h0000_0009) begin errors++; $display("FAIL status_drained: got %h want 00000009", r); end
    endtask

    task automatic test_registers;
        logic [9:0]  bits;
        logic        st;
        logic [31:0] r;
        bus_write(32'h14, 32'h8, 4'h1);
        bus_read(32'h14, r);
        checks++; if (r !== 32'h0000_0001) begin errors++; $display("FAIL ovf_clear: got %h want 00000001", r); end
        bus_write(32'h08, 32'hFFFF_01FF, 4'b0010);
        bus_read(32'h08, r);
        checks++; if (r !== 32'h0000_0109) begin errors++; $display("FAIL div_bytestrobe: got %h want 00000109", r); end
        bus_write(32'h08, 32'd9, 4'hF);
        bus_write(32'h00, 32'hA5, 4'h1);
        bus_write(32'h00, 32'h3C, 4'h1);
        fork
            capture_frame(0, 9, bits, st);
            begin
                repeat (20) @(posedge clk);
                bus_write(32'h08, 32'd0, 4'hF);
            end
        join
        checks++; if (bits !== 10'b1_1010_0101_0 || !st) begin errors++; $display("FAIL frame_A5_div9: got %b stable=%b want 1101001010", bits, st); end
        capture_frame(0, 0, bits, st);
        checks++; if (bits !== 10'b1_0011_1100_0 || !st) begin errors++; $display("FAIL frame_3C_div0: got %b stable=%b want 1001111000", bits, st); end
        checks++; if (uart_tx[0] !== 1'b1) begin errors++; $display("FAIL idle_after_div0: got %b want 1", uart_tx[0]); end
        bus_write(32'h08, 32'd9, 4'hF);
    endtask

    task automatic test_enable_flush;
        logic [9:0]  bits;
        logic        st;
        logic        held;
        logic [31:0] r;
        bus_write(32'h00, 32'h01, 4'h1);
        fork
            begin
                @(posedge clk); #1;
                capture_frame(0, 9, bits, st);
            end
            begin
                bus_write(32'h00, 32'h02, 4'h1);
                bus_write(32'h00, 32'h03, 4'h1);
                repeat (10) @(posedge clk);
                bus_write(32'h0C, 32'h0, 4'h1);
            end
        join
        checks++; if (bits !== 10'b1_0000_0001_0 || !st) begin errors++; $display("FAIL frame_01_en_off: got %b stable=%b want 1000000010", bits, st); end
        held = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (uart_tx[0] !== 1'b1) held = 1'b0;
            @(posedge clk); #1;
        end
        checks++; if (!held) begin errors++; $display("FAIL en_off_hold: line left idle, got 0 want 1"); end
        bus_read(32'h04, r);
        checks++; if (r !== 32'h0002_0000) begin errors++; $display("FAIL status_en_off: got %h want 00020000", r); end
        bus_write(32'h0C, 32'h1, 4'h1);
        @(posedge clk); #1;
        fork
            capture_frame(0, 9, bits, st);
            begin
                repeat (30) @(posedge clk);
                bus_write(32'h0C, 32'h5, 4'h1);
            end
        join
        checks++; if (bits !== 10'b1_0000_0010_0 || !st) begin errors++; $display("FAIL frame_02_flush: got %b stable=%b want 1000000100", bits, st); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (uart_tx[0] !== 1'b1) begin errors++; $display("FAIL idle_after_flush: got %b want 1", uart_tx[0]); end
        bus_read(32'h04, r);
        checks++; if (r !== 32'h0000_0001) begin errors++; $display("FAIL status_flushed: got %h want 00000001", r); end
        bus_read(32'h0C, r);
        checks++; if (r !== 32'h0000_0001) begin errors++; $display("FAIL ctrl_flush_reads0: got %h want 00000001", r); end
    endtask

    task automatic test_irq_unmapped;
        logic [9:0]  bits;
        logic        st;
        logic [31:0] r;
        bus_write(32'h0C, 32'h3, 4'h1);
        checks++; if (tx_irq !== 2'b01) begin errors++; $display("FAIL irq_set: got %b want 01", tx_irq); end
        // simultaneous push and STATUS read: read sees the pre-write FIFO
        @(negedge clk);
        io_wen = 1'b1; io_waddr = 32'h00; io_wdata = 32'h5A; io_wstrb = 4'h1;
        io_ren = 1'b1; io_raddr = 32'h04;
        @(posedge clk); #1;
        io_wen = 1'b0; io_ren = 1'b0; io_wstrb = '0;
        checks++; if (io_rdata !== 32'h0000_0001) begin errors++; $display("FAIL rw_same_cycle: got %h want 00000001", io_rdata); end
        checks++; if (tx_irq !== 2'b00) begin errors++; $display("FAIL irq_push_clear: got %b want 00", tx_irq); end
        @(posedge clk); #1;
        capture_frame(0, 9, bits, st);
        checks++; if (bits !== 10'b1_0101_1010_0 || !st) begin errors++; $display("FAIL frame_5A: got %b stable=%b want 1010110100", bits, st); end
        checks++; if (tx_irq !== 2'b01) begin errors++; $display("FAIL irq_after_stop: got %b want 01", tx_irq); end
        bus_read(32'h0C, r);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (io_rdata !== 32'h0000_0003) begin errors++; $display("FAIL rdata_hold: got %h want 00000003", io_rdata); end
        bus_read(32'h40, r);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL unmapped_40: got %h want 0", r); end
        bus_write(32'h2C, 32'h0, 4'h1);
        bus_read(32'h0C, r);
        bus_read(32'h28, r);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL unmapped_ch2: got %h want 0", r); end
        bus_write(32'h0C, 32'h1, 4'h1);
    endtask

    task automatic test_async_reset;
        logic [31:0] r;
        bus_write(32'h08, 32'd5, 4'hF);
        bus_write(32'h00, 32'h00, 4'h1);
        bus_write(32'h00, 32'h00, 4'h1);
        bus_read(32'h08, r);
        checks++; if (r !== 32'd5) begin errors++; $display("FAIL div_5: got %h want 00000005", r); end
        repeat (14) @(posedge clk);
        #1;
        checks++; if (uart_tx[0] !== 1'b0) begin errors++; $display("FAIL mid_data_low: got %b want 0", uart_tx[0]); end
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++; if (uart_tx !== 2'b11) begin errors++; $display("FAIL async_rst_tx: got %b want 11", uart_tx); end
        checks++; if (io_rdata !== 32'd0) begin errors++; $display("FAIL async_rst_rdata: got %h want 0", io_rdata); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus_read(32'h04, r);
        checks++; if (r !== 32'h0000_0001) begin errors++; $display("FAIL rst_fifo_empty: got %h want 00000001", r); end
        bus_read(32'h08, r);
        checks++; if (r !== 32'd9) begin errors++; $display("FAIL rst_div: got %h want 00000009", r); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        test_reset;
        test_single_frame;
        test_back_to_back;
        test_registers;
        test_enable_flush;
        test_irq_unmapped;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
